csram_param_loader: RTL and testbench
=====================================

CSRAM_PARAM_LOADER -- requirements
Module: csram_param_loader

Interface
REQ-001 SHALL have parameter WIDTHB, default 32: parameter word width.
REQ-002 SHALL have parameter SIZEB, default 4096: parameter-port depth in words.
REQ-003 SHALL have parameter ADDRWIDTHB, default $clog2(SIZEB): parameter address width.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous reset, active-low.
REQ-006 SHALL have ports cmd_valid in 1 / cmd_ready out 1: command handshake.
REQ-007 SHALL have port cmd_write  in  1: 1 = write burst, 0 = readback burst.
REQ-008 SHALL have port cmd_addr  in  ADDRWIDTHB: burst start word address.
REQ-009 SHALL have port cmd_len  in  ADDRWIDTHB+1: burst length in words.
REQ-010 SHALL have ports wr_valid in 1 / wr_ready out 1 / wr_data in WIDTHB: write-data stream.
REQ-011 SHALL have ports rd_valid out 1 / rd_ready in 1 / rd_data out WIDTHB: readback stream.
REQ-012 SHALL have ports param_wen out 1, param_addr out ADDRWIDTHB, param_data_in out WIDTHB: drive the core parameter port.
REQ-013 SHALL have port param_data_out  in  WIDTHB: core read data, valid one cycle after param_addr presents the address.
REQ-014 SHALL have ports busy out 1, done out 1, cmd_error out 1: status.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-017 On an accepted command with cmd_len==0 or cmd_addr+cmd_len>SIZEB, the block SHALL pulse cmd_error for one cycle on the next cycle, stay in IDLE, and issue no param access.
REQ-018 On a legal accepted command, the block SHALL latch the address and remaining count, then enter WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 In WRITE, wr_ready SHALL be 1 while remaining>0.
REQ-021 In WRITE, each wr handshake in cycle N SHALL produce, in cycle N+1, param_wen=1, param_addr=current address, param_data_in=wr_data; then the address SHALL increment and the remaining count decrement.
REQ-022 In WRITE, param_wen SHALL be 0 in cycles with no preceding handshake; sustained throughput SHALL be 1 word/cycle.
REQ-023 After the last write word is issued, the block SHALL enter DONE.
REQ-024 In READ, param_wen SHALL stay 0 and param_addr SHALL be registered.
REQ-025 In READ, a read SHALL be issued only when (output FIFO occupancy + reads in flight) < 4.
REQ-026 In READ, returned param_data_out SHALL be captured into a 4-entry output FIFO.
REQ-027 rd_valid SHALL equal FIFO non-empty, and rd_data SHALL be the FIFO head.
REQ-028 rd_data SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-029 Readback SHALL have no loss or duplication, and data SHALL be delivered in address order.
REQ-030 With rd_ready held at 1, readback throughput SHALL be 1 word/cycle after the initial latency.
REQ-031 READ SHALL enter DONE when all cmd_len words have been accepted on the rd stream.
REQ-032 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-033 Addresses SHALL increment by 1 and never wrap; the last address SHALL be cmd_addr+cmd_len-1 and SHALL be <= SIZEB-1.

Reset
REQ-034 While rst=0, the block SHALL asynchronously force FSM=IDLE, FIFO empty, in-flight count=0, and all outputs 0 except cmd_ready=1.
REQ-035 Reset mid-burst SHALL abandon the transfer; param_wen SHALL drop immediately; no done pulse SHALL be generated.

Verification
REQ-036 Write 0x010 len 4, wr_data A0..A3 back-to-back -> param_wen high 4 consecutive cycles, addr 0x010..0x013 with data A0..A3, one done pulse, cmd_ready=1 next cycle.
REQ-037 Memory model preloaded with A0..A3 at 0x010, read 0x010 len 4, rd_ready=1 -> rd_data A0..A3 in order on consecutive cycles, param_wen never 1, one done pulse.
REQ-038 Read len 8 with rd_ready alternating 1/0 -> exactly 8 words, in order, rd_data stable during stalls, FIFO occupancy never above 4.
REQ-039 Commands addr 0xFFE len 3 and len 0 -> cmd_error pulse each, no param_wen, busy 0; addr 0xFFF len 1 -> accepted and completes.
REQ-040 Write len 4 with wr_valid gaps (1,0,0,1,1,0,1) -> param_wen exactly 4 cycles, each 1 cycle after its handshake, addresses contiguous.
REQ-041 rst=0 after 2 of 4 write words -> param_wen=0 and busy=0 immediately, no done pulse; after release a read len 2 completes normally.

Source files
------------

// File: rtl/csram_param_loader.sv
// Burst loader between a host command/stream interface and a core's single-port
// parameter RAM: write bursts stream into the RAM, read bursts return through a 4-deep FIFO.
module csram_param_loader #(
   parameter int WIDTHB     = 32,
   parameter int SIZEB      = 4096,
   parameter int ADDRWIDTHB = $clog2(SIZEB)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDRWIDTHB-1:0] cmd_addr,
   input  logic [ADDRWIDTHB:0]   cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTHB-1:0]     wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [WIDTHB-1:0]     rd_data,
   output logic                  param_wen,
   output logic [ADDRWIDTHB-1:0] param_addr,
   output logic [WIDTHB-1:0]     param_data_in,
   input  logic [WIDTHB-1:0]     param_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  cmd_error
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

   localparam logic [ADDRWIDTHB-1:0] ONE_A = ADDRWIDTHB'(1);
   localparam logic [ADDRWIDTHB:0]   ONE_L = (ADDRWIDTHB+1)'(1);

   state_e                  state_q, state_d;
   logic [ADDRWIDTHB-1:0]   addr_q, addr_d;
   logic [ADDRWIDTHB:0]     rem_q, rem_d;
   logic [ADDRWIDTHB:0]     left_q, left_d;
   logic                    wen_q, wen_d;
   logic [ADDRWIDTHB-1:0]   pa_q, pa_d;
   logic [WIDTHB-1:0]       pd_q, pd_d;
   logic                    err_q, err_d;
   logic                    pend_q, pend_d;
   logic                    cap_q;
   logic [3:0][WIDTHB-1:0]  fifo_q;
   logic [1:0]              wptr_q, rptr_q;
   logic [2:0]              cnt_q;

   logic [ADDRWIDTHB+1:0]   end_w;
   logic                    legal, pop, room, issue;

   assign end_w = {2'b00, cmd_addr} + {1'b0, cmd_len};
   assign legal = (cmd_len != '0) && (end_w <= (ADDRWIDTHB+2)'(SIZEB));

   assign rd_valid      = (cnt_q != 3'd0);
   assign rd_data       = fifo_q[rptr_q];
   assign pop           = rd_valid && rd_ready;
   // Words already in the FIFO plus those still in the RAM pipeline must fit in 4 slots.
   assign room          = ({1'b0, cnt_q} + {3'b000, pend_q} + {3'b000, cap_q}) < 4'd4;

   assign param_wen     = wen_q;
   assign param_addr    = pa_q;
   assign param_data_in = pd_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign cmd_error     = err_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      left_d    = left_q;
      wen_d     = 1'b0;
      pa_d      = pa_q;
      pd_d      = pd_q;
      err_d     = 1'b0;
      pend_d    = 1'b0;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      issue     = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (legal) begin
                  addr_d  = cmd_addr;
                  rem_d   = cmd_len;
                  left_d  = cmd_len;
                  state_d = cmd_write ? WRITE : READ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WRITE: begin
            wr_ready = (rem_q != '0);
            if (wr_valid && wr_ready) begin
               wen_d  = 1'b1;
               pa_d   = addr_q;
               pd_d   = wr_data;
               addr_d = addr_q + ONE_A;
               rem_d  = rem_q - ONE_L;
            end
            // rem hits zero in the cycle the final word is on the RAM port.
            if (rem_q == '0) state_d = DONE;
         end
         READ: begin
            issue = (rem_q != '0) && room;
            if (issue) begin
               pa_d   = addr_q;
               pend_d = 1'b1;
               addr_d = addr_q + ONE_A;
               rem_d  = rem_q - ONE_L;
            end
            if (pop) begin
               left_d = left_q - ONE_L;
               if (left_q == ONE_L) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         left_q  <= '0;
         wen_q   <= 1'b0;
         pa_q    <= '0;
         pd_q    <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         left_q  <= left_d;
         wen_q   <= wen_d;
         pa_q    <= pa_d;
         pd_q    <= pd_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         cap_q   <= pend_q;
      end
   end

   // cap_q marks the cycle in which param_data_out holds the word addressed two cycles ago.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q <= '0;
         wptr_q <= 2'd0;
         rptr_q <= 2'd0;
         cnt_q  <= 3'd0;
      end else begin
         if (cap_q) begin
            fifo_q[wptr_q] <= param_data_out;
            wptr_q         <= wptr_q + 2'd1;
         end
         if (pop) rptr_q <= rptr_q + 2'd1;
         case ({cap_q, pop})
            2'b10:   cnt_q <= cnt_q + 3'd1;
            2'b01:   cnt_q <= cnt_q - 3'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_csram_param_loader.sv
// Scoreboard bench: tasks push expected RAM writes / readback words, a negedge monitor pops and compares.
module tb_csram_param_loader;
   localparam int W = 32, S = 4096, AW = 12;

   logic clk = 1'b0, rst = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0] cmd_len = '0;
   logic wr_valid = 1'b0, wr_ready;
   logic [W-1:0] wr_data = '0;
   logic rd_valid, rd_ready = 1'b1;
   logic [W-1:0] rd_data;
   logic param_wen;
   logic [AW-1:0] param_addr;
   logic [W-1:0] param_data_in, pdo;
   logic busy, done, cmd_error;

   csram_param_loader #(.WIDTHB(W), .SIZEB(S), .ADDRWIDTHB(AW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .param_wen(param_wen), .param_addr(param_addr), .param_data_in(param_data_in),
      .param_data_out(pdo), .busy(busy), .done(done), .cmd_error(cmd_error));

   initial forever #5 clk = ~clk;

   // Core parameter RAM: synchronous write, one-cycle read latency.
   logic [W-1:0] mem [0:S-1];
   always @(posedge clk) begin
      if (param_wen) mem[param_addr] <= param_data_in;
      pdo <= mem[param_addr];
   end

   typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} wr_t;
   wr_t          exp_wr[$];
   logic [W-1:0] exp_rd[$];
   logic [W-1:0] wdat [0:15];
   logic [W-1:0] rexp [0:15];

   int applied = 0, errs = 0;
   int done_cnt = 0, err_cnt = 0, wen_cnt = 0, pop_cnt = 0, run = 0, last_pop = -10, cyc = 0;
   logic prev_hs = 1'b0, prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   wr_t me;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      applied++;
      errs++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         prev_hs    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (cmd_error) err_cnt++;
         if (prev_hs || param_wen) chk("wen_follows_handshake", 64'(param_wen), 64'(prev_hs));
         if (param_wen) begin
            wen_cnt++;
            if (exp_wr.size() == 0) flag("unexpected_param_write");
            else begin
               me = exp_wr.pop_front();
               chk("wr_addr", 64'(param_addr), 64'(me.a));
               chk("wr_data", 64'(param_data_in), 64'(me.d));
            end
         end
         if (prev_stall) begin
            chk("rd_hold_valid", 64'(rd_valid), 64'(1));
            chk("rd_hold_data", 64'(rd_data), 64'(prev_data));
         end
         if (rd_valid && rd_ready) begin
            pop_cnt++;
            run      = (cyc == last_pop + 1) ? run + 1 : 1;
            last_pop = cyc;
            if (exp_rd.size() == 0) flag("unexpected_rd_word");
            else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
         end
         prev_hs    = wr_valid && wr_ready;
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
      end
   end

   task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input int len);
      int g = 0;
      cmd_write = w; cmd_addr = a; cmd_len = 13'(len); cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
      if (!cmd_ready) flag("cmd_ready_timeout");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input logic alt);
      int g;
      for (g = 0; g < 300; g++) begin
         if (alt) rd_ready = ~rd_ready;
         @(negedge clk);
         if (done) break;
         @(posedge clk); #1;
      end
      if (g >= 300) flag("done_timeout");
      @(posedge clk); #1;
      rd_ready = 1'b1;
      @(negedge clk);
      chk("ready_after_done", 64'(cmd_ready), 64'(1));
      chk("idle_after_done", 64'(busy), 64'(0));
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input int len, input logic [15:0] pat, input int plen);
      int w0 = wen_cnt, d0 = done_cnt, k = 0, p = 0, g = 0;
      logic hs;
      for (int i = 0; i < len; i++) exp_wr.push_back('{a: a + AW'(i), d: wdat[i]});
      issue_cmd(1'b1, a, len);
      while (k < len && g < 100) begin
         wr_valid = pat[p % plen];
         wr_data  = wdat[k];
         @(negedge clk);
         hs = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (hs) k++;
         p++; g++;
      end
      wr_valid = 1'b0;
      if (k < len) flag("write_stream_timeout");
      wait_done(1'b0);
      chk("wr_count", 64'(wen_cnt - w0), 64'(len));
      chk("wr_done_pulses", 64'(done_cnt - d0), 64'(1));
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int len, input logic alt);
      int p0 = pop_cnt, d0 = done_cnt, w0 = wen_cnt;
      for (int i = 0; i < len; i++) exp_rd.push_back(rexp[i]);
      rd_ready = 1'b1;
      issue_cmd(1'b0, a, len);
      wait_done(alt);
      chk("rd_count", 64'(pop_cnt - p0), 64'(len));
      chk("rd_done_pulses", 64'(done_cnt - d0), 64'(1));
      chk("rd_no_wen", 64'(wen_cnt - w0), 64'(0));
   endtask

   task automatic bad_cmd(input logic [AW-1:0] a, input int len);
      int e0 = err_cnt, w0 = wen_cnt;
      issue_cmd(1'b1, a, len);
      @(negedge clk);
      chk("err_pulse", 64'(cmd_error), 64'(1));
      chk("err_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("err_one_cycle", 64'(cmd_error), 64'(0));
      chk("err_stays_idle", 64'(cmd_ready), 64'(1));
      repeat (2) @(negedge clk);
      chk("err_count", 64'(err_cnt - e0), 64'(1));
      chk("err_no_wen", 64'(wen_cnt - w0), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int d0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_cmd_error", 64'(cmd_error), 64'(0));
      chk("rst_wen", 64'(param_wen), 64'(0));
      chk("rst_wr_ready", 64'(wr_ready), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_param_addr", 64'(param_addr), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // back-to-back write burst, then read it back with rd_ready held high
      for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
      do_write(12'h010, 4, 16'h0001, 1);
      rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
      do_read(12'h010, 4, 1'b0);
      chk("rd_back_to_back", 64'(run), 64'(4));

      // 8-word readback with alternating rd_ready
      for (int i = 0; i < 8; i++) wdat[i] = 32'hB0 + 32'(i);
      do_write(12'h100, 8, 16'h0001, 1);
      rexp[0] = 32'hB0; rexp[1] = 32'hB1; rexp[2] = 32'hB2; rexp[3] = 32'hB3;
      rexp[4] = 32'hB4; rexp[5] = 32'hB5; rexp[6] = 32'hB6; rexp[7] = 32'hB7;
      do_read(12'h100, 8, 1'b1);

      // range errors and the last legal word
      bad_cmd(12'hFFE, 3);
      bad_cmd(12'h020, 0);
      wdat[0] = 32'hC5;
      do_write(12'hFFF, 1, 16'h0001, 1);
      rexp[0] = 32'hC5;
      do_read(12'hFFF, 1, 1'b0);

      // write with wr_valid gaps 1,0,0,1,1,0,1
      for (int i = 0; i < 4; i++) wdat[i] = 32'hE0 + 32'(i);
      do_write(12'h020, 4, 16'h0059, 7);
      rexp[0] = 32'hE0; rexp[1] = 32'hE1; rexp[2] = 32'hE2; rexp[3] = 32'hE3;
      do_read(12'h020, 4, 1'b0);

      // reset after two of four write words
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) exp_wr.push_back('{a: 12'h030 + AW'(i), d: 32'hD0 + 32'(i)});
      issue_cmd(1'b1, 12'h030, 4);
      wr_valid = 1'b1; wr_data = 32'hD0;
      @(posedge clk); #1;
      wr_data = 32'hD1;
      @(posedge clk); #1;
      chk("pre_rst_wen", 64'(param_wen), 64'(1));
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_wen", 64'(param_wen), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
      wr_valid = 1'b0;
      exp_wr.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
      @(posedge clk); #1;
      rexp[0] = 32'hA0; rexp[1] = 32'hA1;
      do_read(12'h010, 2, 1'b0);

      chk("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
      chk("rd_queue_drained", 64'(exp_rd.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
      $finish;
   end
endmodule
